// File: rtl/lfa_adc_pkg.sv
// Shared definitions for the LFA ADC128S022 sampler.
// Holds the sequencer state encoding, the frame geometry, the bit positions
// where the 3-bit channel address travels on DIN, and the default channel
// assignment for the left/middle/right sensors.
package lfa_adc_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_XFER  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    // One frame is 16 SCLK periods, each split into a low and a high phase.
    localparam int unsigned FRAME_PHASES = 32;
    localparam logic [4:0]  PH_LAST      = 5'(FRAME_PHASES - 1);

    // Bit slots (SCLK period index) carrying ADD2, ADD1, ADD0.
    localparam logic [3:0] K_ADDR2 = 4'd2;
    localparam logic [3:0] K_ADDR1 = 4'd3;
    localparam logic [3:0] K_ADDR0 = 4'd4;

    localparam logic [2:0] CH_LEFT_DEF   = 3'd3;
    localparam logic [2:0] CH_MIDDLE_DEF = 3'd2;
    localparam logic [2:0] CH_RIGHT_DEF  = 3'd1;

    // DIN value for bit slot k: the address MSB first in slots 2..4, else 0.
    function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] addr);
        logic b;
        case (k)
            K_ADDR2: b = addr[2];
            K_ADDR1: b = addr[1];
            K_ADDR0: b = addr[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lfa_adc_frame.sv
// Serial transfer engine for one ADC128S022 frame (32 system clocks).
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_start          one-cycle request; the next cycle is phase 0
//   i_addr           channel address shifted out on DIN in bit slots 2..4
//   i_dout           ADC DOUT, captured at the end of every SCLK-high phase
//   o_sclk, o_din    registered SCLK (idles high) and DIN
//   o_last           high during the final phase of the frame
//   o_done           one-cycle pulse in the cycle after the final phase
//   o_data           12-bit conversion result of the frame
module lfa_adc_frame
    import lfa_adc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_addr,
    input  logic        i_dout,
    output logic        o_sclk,
    output logic        o_din,
    output logic        o_last,
    output logic        o_done,
    output logic [11:0] o_data
);

    logic        r_active;
    logic [4:0]  r_ph;
    logic        r_sclk;
    logic        r_din;
    logic        r_done;
    // Only the trailing 12 bits of the 16-bit word are kept: the four
    // leading bits shift out of the top and are never needed.
    logic [11:0] r_sr;
    logic [4:0]  w_ph_nxt;

    assign w_ph_nxt = r_ph + 5'd1;
    assign o_last   = r_active & (r_ph == PH_LAST);
    assign o_sclk   = r_sclk;
    assign o_din    = r_din;
    assign o_done   = r_done;
    assign o_data   = r_sr;

    // Phase counter, SCLK/DIN generation and MSB-first DOUT capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_ph     <= 5'd0;
            r_sclk   <= 1'b1;
            r_din    <= 1'b0;
            r_done   <= 1'b0;
            r_sr     <= 12'd0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                // Phase 0 starts with a falling SCLK; slot 0 carries no address.
                r_active <= 1'b1;
                r_ph     <= 5'd0;
                r_sclk   <= 1'b0;
                r_din    <= 1'b0;
            end else if (r_active) begin
                // Leaving an SCLK-high phase: DOUT has been stable a full period.
                if (r_ph[0]) begin
                    r_sr <= {r_sr[10:0], i_dout};
                end
                if (r_ph == PH_LAST) begin
                    r_active <= 1'b0;
                    r_ph     <= 5'd0;
                    r_sclk   <= 1'b1;
                    r_din    <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_ph   <= w_ph_nxt;
                    r_sclk <= w_ph_nxt[0];
                    // DIN changes only with the falling SCLK edge.
                    if (!w_ph_nxt[0]) begin
                        r_din <= addr_bit(w_ph_nxt[4:1], i_addr);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lfa_adc_sampler.sv
// Round-robin sampler for the left/middle/right line sensors on the
// ADC128S022. Each 34-clock frame addresses the next channel and receives
// the conversion of the channel addressed in the previous frame; that result
// is routed by the previous-frame tag into the matching output register.
// Ports:
//   clk_3125KHz, rst_n           clock, asynchronous active-low reset
//   en                           conversion enable, looked at between frames
//   adc_dout                     ADC DOUT
//   adc_cs_n, adc_sclk, adc_din  ADC chip select, serial clock, DIN
//   left, middle, right          latest 12-bit conversion per sensor
//   sample_valid                 one-cycle pulse when right is refreshed
module lfa_adc_sampler
    import lfa_adc_pkg::*;
#(
    parameter logic [2:0] CH_LEFT   = CH_LEFT_DEF,
    parameter logic [2:0] CH_MIDDLE = CH_MIDDLE_DEF,
    parameter logic [2:0] CH_RIGHT  = CH_RIGHT_DEF
)
(
    input  logic        clk_3125KHz,
    input  logic        rst_n,
    input  logic        en,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    output logic [11:0] left,
    output logic [11:0] middle,
    output logic [11:0] right,
    output logic        sample_valid
);

    state_t      r_state;
    logic        r_cs_n;
    logic [2:0]  r_next_addr;
    logic [2:0]  r_addr_cur;
    logic [2:0]  r_addr_prev;
    logic        r_tag_valid;
    logic [11:0] r_left;
    logic [11:0] r_middle;
    logic [11:0] r_right;
    logic        r_sample_valid;

    logic        w_start;
    logic        w_last;
    logic        w_done;
    logic [11:0] w_data;

    assign w_start      = (r_state == S_START) & en;
    assign adc_cs_n     = r_cs_n;
    assign left         = r_left;
    assign middle       = r_middle;
    assign right        = r_right;
    assign sample_valid = r_sample_valid;

    lfa_adc_frame u_frame (
        .i_clk   (clk_3125KHz),
        .i_rst_n (rst_n),
        .i_start (w_start),
        .i_addr  (r_addr_cur),
        .i_dout  (adc_dout),
        .o_sclk  (adc_sclk),
        .o_din   (adc_din),
        .o_last  (w_last),
        .o_done  (w_done),
        .o_data  (w_data)
    );

    // Frame sequencer, channel rotation, pipeline tag and output registers.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_START;
            r_cs_n         <= 1'b1;
            r_next_addr    <= CH_LEFT;
            r_addr_cur     <= CH_LEFT;
            r_addr_prev    <= 3'd0;
            r_tag_valid    <= 1'b0;
            r_left         <= 12'd0;
            r_middle       <= 12'd0;
            r_right        <= 12'd0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                S_START: begin
                    if (en) begin
                        r_addr_cur <= r_next_addr;
                        r_cs_n     <= 1'b0;
                        r_state    <= S_XFER;
                    end else begin
                        // An idle gap breaks the pipeline: the next frame
                        // returns data for an address nobody is tracking.
                        r_tag_valid <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (w_last) begin
                        r_cs_n  <= 1'b1;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_tag_valid && w_done) begin
                        if (r_addr_prev == CH_LEFT) begin
                            r_left <= w_data;
                        end else if (r_addr_prev == CH_MIDDLE) begin
                            r_middle <= w_data;
                        end else if (r_addr_prev == CH_RIGHT) begin
                            r_right        <= w_data;
                            r_sample_valid <= 1'b1;
                        end
                    end
                    r_addr_prev <= r_addr_cur;
                    r_tag_valid <= 1'b1;
                    if (r_next_addr == CH_LEFT) begin
                        r_next_addr <= CH_MIDDLE;
                    end else if (r_next_addr == CH_MIDDLE) begin
                        r_next_addr <= CH_RIGHT;
                    end else begin
                        r_next_addr <= CH_LEFT;
                    end
                    r_state <= S_START;
                end
                default: begin
                    r_state <= S_START;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/lfa_adc_sampler.md
# lfa_adc_sampler

Upstream front end of the line-follower: drives the ADC128S022 8-channel SPI ADC on the line-follower array (LFA) board. It samples the left, middle and right sensor channels round-robin and presents them as registered 12-bit values on the `left`/`middle`/`right` inputs of the line-following controller, plus a one-cycle `sample_valid` strobe each time a full triple has refreshed. Runs entirely in the 3.125 MHz motor/control clock domain.

## Interface
- `CH_LEFT`, default 3'd3: ADC channel wired to the left sensor.
- `CH_MIDDLE`, default 3'd2: ADC channel wired to the middle sensor.
- `CH_RIGHT`, default 3'd1: ADC channel wired to the right sensor.
- `clk_3125KHz`  in  1: system clock, 3.125 MHz, single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `en`  in  1: conversion enable. Sampled only at frame start.
- `adc_dout`  in  1: ADC serial data out (DOUT).
- `adc_cs_n`  out  1: ADC chip select, active-low.
- `adc_sclk`  out  1: ADC serial clock, clk/2 = 1.5625 MHz during a frame; idles high.
- `adc_din`  out  1: ADC serial data in (DIN, carries the channel address).
- `left`  out  12: latest left-sensor conversion.
- `middle`  out  12: latest middle-sensor conversion.
- `right`  out  12: latest right-sensor conversion.
- `sample_valid`  out  1: one-cycle pulse; `right` was just written, so the triple is complete.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `adc_din`=0, `left`/`middle`/`right`=0, `sample_valid`=0.
- Reset state: state S_START, next-address = `CH_LEFT`, tag-valid = 0.
- FSM has three states.
  - S_START: `cs_n`=1, `sclk`=1, 1 cycle. If `en`=1, load `addr_cur` ← next-address and go to S_XFER. Otherwise stay in S_START.
  - S_XFER: `cs_n`=0, 32 cycles, phase counter `ph` 0..31, bit index k = `ph`>>1.
    - `sclk` = 0 on even `ph`, 1 on odd `ph`. The falling edge is at the start of even phases.
    - `adc_din` is registered and updated on entry to each even phase. For k=2,3,4 it carries `addr_cur`[2], [1], [0]; for all other k it is 0.
    - On the clock edge leaving each odd phase, shift `adc_dout` into a 16-bit shift register, MSB first.
    - After `ph`=31, go to S_LATCH.
  - S_LATCH: `cs_n`=1, `sclk`=1, 1 cycle.
    - The ADC pipeline returns, in frame n, the channel addressed in frame n−1. Data goes to the register selected by the previous-frame tag `addr_prev`, using `sr[11:0]`. The upper 4 bits are ignored.
    - If tag-valid = 0, discard the data. This covers the first frame after reset and the first frame after an `en`-low gap.
    - Then set `addr_prev` ← `addr_cur`, tag-valid ← 1, advance next-address L→M→R→L, and go to S_START.
- `sample_valid` is asserted in the same cycle the `right` register takes its new value.
- `en` deasserted mid-frame: the current frame completes and latches normally. S_START then holds, and tag-valid is cleared so the next frame's data is discarded.
- `rst_n` asserted mid-frame: outputs go to reset values immediately and asynchronously. `cs_n` rises, aborting the ADC frame. The restart is a fresh first frame, which is discarded.

## Timing
- Frame length is 34 clocks (1 + 32 + 1), about 10.9 µs. One full L/M/R triple takes 102 clocks, about 32.6 µs.
- Data latency: a channel's value appears 2 frames (68 clocks) after its address frame starts.
- In steady state, `sample_valid` pulses once every 102 clocks, and never on two consecutive cycles.
- Output registers change only in S_LATCH cycles and hold their value otherwise.
- `adc_dout` is sampled one full SCLK period after the ADC's launching falling edge. This satisfies tDOUT at 1.5625 MHz.

## Structure
- Package `lfa_adc_pkg` holds:
  - state encoding S_START/S_XFER/S_LATCH;
  - `FRAME_PHASES`=32;
  - address bit positions k = 2..4;
  - default channel codes.
- One natural sub-module, `lfa_adc_frame`: the S_XFER engine. It takes a 3-bit address in, produces a 12-bit result with a done pulse, and owns `sclk`, `din` and the shift register.
- The top level keeps the round-robin sequencing, tag logic and output registers.

## Test plan
- Behavioural ADC model returns 12'hABC for ch3, 12'h123 for ch2 and 12'hFFF for ch1, with reset released and `en`=1. Required response:
  - the first frame is discarded;
  - `left`=ABC, `middle`=123, `right`=FFF;
  - `sample_valid` first rises 136 clocks after reset release, then repeats every 102 clocks.
- Protocol check on every frame:
  - `cs_n` is low for exactly 32 clocks;
  - 16 `sclk` rising edges occur;
  - `din` on rising edges 3–5 equals the L, M, R address sequence;
  - `din` is 0 on all other rising edges.
- Model returns all zeros, then 12'h000 / 12'h7FF alternating per triple. Required response: outputs track the model exactly, with no channel cross-talk, and `sr` upper bits are ignored when the model drives 4'hF.
- Drop `en` mid-frame. Required response: that frame completes, `cs_n` stays high while `en`=0, and after re-enable the first frame is discarded with no wrong-channel write.
- Assert `rst_n` at `ph`=17. Required response: `cs_n`=1, `sclk`=1 and all outputs 0 in the same cycle; on release, operation restarts cleanly with channel L.
- Set `CH_LEFT`=0, `CH_MIDDLE`=7, `CH_RIGHT`=4. Required response: addresses 000, 111, 100 appear on `din`, and data maps to the correct output ports.
